// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between the CPU datapath/board I/O and cpu_run_ctrl.
// The master drives the switches, button, breakpoint setup and PC, and observes the step enable.
interface cpu_run_ctrl_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic            step_key;
  logic            halt_req;
  logic            brk_en;
  logic [PC_W-1:0] brk_addr;
  logic [PC_W-1:0] pc;
  logic            step_en;
  logic [1:0]      state;
  logic            brk_hit;
  logic [15:0]     step_cnt;

  modport master (
    output run, step_key, halt_req, brk_en, brk_addr, pc,
    input  step_en, state, brk_hit, step_cnt
  );

  modport slave (
    input  run, step_key, halt_req, brk_en, brk_addr, pc,
    output step_en, state, brk_hit, step_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: issues one-cycle step enables to the single-cycle CPU
// in free-run, single-step (debounced button) or breakpoint-halt modes.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE 00 | stopped; waits for run switch or a button press
// RUN  01 | free-run; one step per prescaler tick, breakpoint checked
// STEP 10 | manual step pulse in flight; returns to IDLE
// BRK  11 | halted on breakpoint; press steps past it and resumes RUN
module cpu_run_ctrl #(
  parameter int DIV_CNT = 25000000,
  parameter int DEB_CNT = 500000,
  parameter int PC_W    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  cpu_run_ctrl_if.slave ctrl_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_e;

  localparam int PRE_W = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_CNT - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  state_e            state_q, state_d;
  logic              step_en_q, step_en_d;
  logic [15:0]       step_cnt_q, step_cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              key_s1_q, key_s2_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              deb_lvl_q, deb_lvl_d;
  logic              press_q, press_d;

  logic              tick;
  logic              brk_match;
  logic              leave_req;
  logic [PC_W-1:0]   pc_cur;
  logic [PC_W-1:0]   pc_brk;

  assign pc_cur    = ctrl_if.pc;
  assign pc_brk    = ctrl_if.brk_addr;
  assign tick      = (pre_q == PRE_LAST);
  assign brk_match = ctrl_if.brk_en && (pc_cur == pc_brk);
  assign leave_req = ctrl_if.halt_req || !ctrl_if.run;

  // The button is asynchronous; both stages idle at the released level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= ctrl_if.step_key;
      key_s2_q <= key_s1_q;
    end
  end

  // A new level is accepted only after DEB_CNT consecutive cycles of disagreement;
  // any cycle of agreement (a bounce back) restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    press_d   = 1'b0;
    if (key_s2_q != deb_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_lvl_d = key_s2_q;
        press_d   = ~key_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_cnt_q <= '0;
      deb_lvl_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_lvl_q <= deb_lvl_d;
      press_q   <= press_d;
    end
  end

  // Prescaler is held at zero outside RUN, so every entry into RUN starts a full period.
  always_comb begin
    state_d   = state_q;
    step_en_d = 1'b0;
    pre_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (!ctrl_if.halt_req && ctrl_if.run) begin
          state_d = ST_RUN;
        end else if (press_q) begin
          state_d   = ST_STEP;
          step_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (leave_req) begin
          state_d = ST_IDLE;
        end else if (tick && brk_match) begin
          state_d = ST_BRK;
        end else begin
          step_en_d = tick;
          pre_d     = tick ? '0 : pre_q + 1'b1;
        end
      end
      ST_BRK: begin
        if (leave_req) begin
          state_d = ST_IDLE;
        end else if (press_q) begin
          state_d   = ST_RUN;
          step_en_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign step_cnt_d = step_cnt_q + {15'd0, step_en_d};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      step_en_q  <= 1'b0;
      step_cnt_q <= '0;
      pre_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_en_q  <= step_en_d;
      step_cnt_q <= step_cnt_d;
      pre_q      <= pre_d;
    end
  end

  assign ctrl_if.step_en  = step_en_q;
  assign ctrl_if.state    = state_q;
  assign ctrl_if.brk_hit  = (state_q == ST_BRK);
  assign ctrl_if.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with literal expectations plus
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_cpu_run_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int PW  = 8;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_BRK  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.PC_W(PW)) bus ();

  cpu_run_ctrl #(.DIV_CNT(DIV), .DEB_CNT(DEB), .PC_W(PW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ctrl_if(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_mode, m_age, m_lvl, m_run, m_press, m_step, m_cnt, h1, h2;
  logic prev_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_age = 0; m_lvl = 1; m_run = 0; m_press = 0;
    m_step = 0; m_cnt = 0; h1 = 1; h2 = 1; prev_en = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held across the edge.
  task automatic model_edge();
    int sync, np, st;
    bit tk;
    sync = h2;
    np   = 0;
    if (sync != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl = sync;
        m_run = 0;
        np    = (sync == 0) ? 1 : 0;
      end
    end else begin
      m_run = 0;
    end
    h2 = h1;
    h1 = int'(bus.step_key);
    st = 0;
    tk = ((m_age % DIV) == DIV - 1);
    case (m_mode)
      M_IDLE: begin
        if (!bus.halt_req && bus.run) begin m_mode = M_RUN; m_age = 0; end
        else if (m_press != 0) begin m_mode = M_STEP; st = 1; end
      end
      M_STEP: m_mode = M_IDLE;
      M_RUN: begin
        if (bus.halt_req || !bus.run) m_mode = M_IDLE;
        else if (tk && bus.brk_en && (bus.pc == bus.brk_addr)) m_mode = M_BRK;
        else begin
          if (tk) st = 1;
          m_age++;
        end
      end
      default: begin
        if (bus.halt_req || !bus.run) m_mode = M_IDLE;
        else if (m_press != 0) begin st = 1; m_mode = M_RUN; m_age = 0; end
      end
    endcase
    m_press = np;
    m_step  = st;
    m_cnt   = (m_cnt + st) % 65536;
  endtask

  always @(posedge clk or negedge rst_n) begin
    #1;
    if (!rst_n) model_reset();
    else        model_edge();
    check("state",    32'(bus.state),    32'(m_mode));
    check("step_en",  32'(bus.step_en),  32'(m_step));
    check("brk_hit",  32'(bus.brk_hit),  (m_mode == M_BRK) ? 32'd1 : 32'd0);
    check("step_cnt", 32'(bus.step_cnt), 32'(m_cnt));
    check("pulse_width", 32'(bus.step_en & prev_en), 32'd0);
    prev_en = bus.step_en;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int   pulses, last_idx, p_at, gap, extra, hold;
  logic [1:0] sts [0:15];
  bit   found;

  initial begin
    bus.run = 1'b0; bus.step_key = 1'b1; bus.halt_req = 1'b0;
    bus.brk_en = 1'b0; bus.brk_addr = 8'h05; bus.pc = 8'h00;

    // reset state
    do_reset();
    check("rst_state",    32'(bus.state),    32'd0);
    check("rst_step_en",  32'(bus.step_en),  32'd0);
    check("rst_brk_hit",  32'(bus.brk_hit),  32'd0);
    check("rst_step_cnt", 32'(bus.step_cnt), 32'd0);

    // free-run for 20 cycles: pulses at samples 5, 9, 13, 17
    bus.run = 1'b1;
    pulses = 0; last_idx = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.step_en) begin pulses++; last_idx = i; end
    end
    check("t1_pulses", 32'(pulses), 32'd4);
    check("t1_last_pulse", 32'(last_idx), 32'd17);
    check("t1_step_cnt", 32'(bus.step_cnt), 32'd4);
    bus.run = 1'b0;
    @(negedge clk);
    check("t1_stop_state", 32'(bus.state), 32'd0);

    // bouncing button, then stable low: exactly one step
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      bus.step_key = i[0];
      @(negedge clk);
      if (bus.step_en) pulses++;
    end
    bus.step_key = 1'b0;
    p_at = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sts[i] = bus.state;
      if (bus.step_en) begin pulses++; p_at = i; end
    end
    check("t2_pulses", 32'(pulses), 32'd1);
    if (p_at >= 0 && p_at < 15) begin
      check("t2_state_at_pulse", 32'(sts[p_at]), 32'd2);
      check("t2_state_after", 32'(sts[p_at+1]), 32'd0);
    end
    check("t2_step_cnt", 32'(bus.step_cnt), 32'd1);
    bus.step_key = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.step_en) extra++;
    end
    check("t2_release_pulses", 32'(extra), 32'd0);

    // breakpoint at PC 05, then step past it
    do_reset();
    bus.brk_en = 1'b1; bus.brk_addr = 8'h05; bus.pc = 8'h05; bus.run = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus.step_en) pulses++;
    end
    check("t3_brk_state", 32'(bus.state), 32'd3);
    check("t3_brk_hit", 32'(bus.brk_hit), 32'd1);
    check("t3_no_pulse", 32'(pulses), 32'd0);
    bus.brk_en = 1'b0; bus.brk_addr = 8'h09;
    repeat (3) @(negedge clk);
    check("t3_brk_hold", 32'(bus.state), 32'd3);
    bus.step_key = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.step_en) begin found = 1'b1; break; end
    end
    check("t3_resume_pulse", 32'(found), 32'd1);
    check("t3_resume_state", 32'(bus.state), 32'd1);
    check("t3_resume_cnt", 32'(bus.step_cnt), 32'd1);
    bus.pc = 8'h06; bus.brk_en = 1'b1; bus.brk_addr = 8'h05; bus.step_key = 1'b1;
    gap = -1;
    for (int g = 1; g <= 20; g++) begin
      @(negedge clk);
      if (bus.step_en) begin gap = g; break; end
    end
    check("t3_next_gap", 32'(gap), 32'd4);
    bus.run = 1'b0; bus.brk_en = 1'b0;
    repeat (8) @(negedge clk);

    // halt and run-off together on a tick: no pulse
    do_reset();
    bus.run = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_cnt_before", 32'(bus.step_cnt), 32'd1);
    bus.halt_req = 1'b1; bus.run = 1'b0;
    @(negedge clk);
    check("t4_state", 32'(bus.state), 32'd0);
    check("t4_step_en", 32'(bus.step_en), 32'd0);
    check("t4_cnt_after", 32'(bus.step_cnt), 32'd1);
    bus.halt_req = 1'b0;

    // step counter wrap
    @(negedge clk);
    force dut.step_cnt_q = 16'hFFFF;
    m_cnt = 65535;
    @(negedge clk);
    check("t5_preload", 32'(bus.step_cnt), 32'h0000FFFF);
    release dut.step_cnt_q;
    bus.step_key = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.step_en) begin found = 1'b1; break; end
    end
    check("t5_pulse", 32'(found), 32'd1);
    check("t5_wrap", 32'(bus.step_cnt), 32'd0);
    bus.step_key = 1'b1;
    repeat (8) @(negedge clk);

    // randomized phase
    do_reset();
    hold = 1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n == 1500) rst_n = 1'b0;
      if (n == 1501) rst_n = 1'b1;
      hold--;
      if (hold <= 0) begin
        bus.step_key = ~bus.step_key;
        hold = int'($urandom_range(1, 8));
      end
      if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 49) == 0) bus.brk_en = ~bus.brk_en;
      bus.halt_req = ($urandom_range(0, 24) == 0);
      bus.pc = 8'($urandom_range(0, 7));
    end
    bus.halt_req = 1'b0; bus.step_key = 1'b1; bus.brk_en = 1'b0;

    // async reset while a step pulse is high
    do_reset();
    bus.run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.step_en) begin found = 1'b1; break; end
    end
    check("t6_pulse_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #2;
    check("t6_step_en", 32'(bus.step_en), 32'd0);
    check("t6_state", 32'(bus.state), 32'd0);
    check("t6_step_cnt", 32'(bus.step_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.run = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
